// File: rtl/ibex_icache_key_gen.sv
// rtl/ibex_icache_key_gen.sv - xorshift64 scrambling key/nonce source for the icache
// Optional stall input enabled by IBEX_ICACHE_KEYGEN_STALL_EN.
module ibex_icache_key_gen #(
    parameter int unsigned KeyW    = 128,
    parameter int unsigned NonceW  = 64,
    parameter int unsigned Latency = 8,
    parameter logic [63:0] Seed    = 64'h0123_4567_89AB_CDEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
`ifdef IBEX_ICACHE_KEYGEN_STALL_EN
    input  logic              stall_i,
`endif
    output logic              valid_o,
    output logic [KeyW-1:0]   key_o,
    output logic [NonceW-1:0] nonce_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [7:0]        LoadCnt    = 8'(Latency - 1);
    localparam logic [KeyW-1:0]   KeyReset   = KeyW'(128'hDDDDDDDD_EEEEEEEE_AAAAAAAA_DDDDDDDD);
    localparam logic [NonceW-1:0] NonceReset = NonceW'(64'hBBBBEEEE_EEEEFFFF);

    state_e      r_state;
    state_e      w_state_n;
    logic [63:0] r_s;
    logic [63:0] w_s_next;
    logic [7:0]  r_cnt;
    logic [63:0] r_kh;
    logic [63:0] r_kl;
    logic [63:0] r_nn;
    logic        w_stall;
    logic        w_adv;

`ifdef IBEX_ICACHE_KEYGEN_STALL_EN
    assign w_stall = stall_i;
`else
    assign w_stall = 1'b0;
`endif

    // Generation only advances in BUSY; a stall freezes s, cnt and the shadows together.
    assign w_adv = (r_state == BUSY) && !w_stall;

    function automatic logic [63:0] f_xorshift(input logic [63:0] s);
        logic [63:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 7);
        t = t ^ (t << 17);
        return t;
    endfunction

    assign w_s_next = f_xorshift(r_s);

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            IDLE:    if (req_i) w_state_n = BUSY;
            BUSY:    if (w_adv && (r_cnt == 8'd0)) w_state_n = RESP;
            RESP:    w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s     <= Seed;
            r_cnt   <= 8'd0;
            r_kh    <= 64'd0;
            r_kl    <= 64'd0;
            r_nn    <= 64'd0;
            key_o   <= KeyReset;
            nonce_o <= NonceReset;
        end else if ((r_state == IDLE) && req_i) begin
            r_cnt <= LoadCnt;
        end else if (w_adv) begin
            r_s <= w_s_next;
            if (r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (r_cnt == 8'd2) begin
                r_kh <= w_s_next;
            end
            if (r_cnt == 8'd1) begin
                r_kl <= w_s_next;
            end
            // Last BUSY cycle: publish outputs so they change on the same edge that enters RESP.
            if (r_cnt == 8'd0) begin
                r_nn    <= w_s_next;
                key_o   <= KeyW'({r_kh, r_kl});
                nonce_o <= NonceW'(w_s_next);
            end
        end
    end

    assign valid_o = (r_state == RESP);
    assign busy_o  = (r_state == BUSY);

endmodule

// File: tb/tb_ibex_icache_key_gen.sv
// tb/tb_ibex_icache_key_gen.sv - randomized self-checking bench for ibex_icache_key_gen
module tb_ibex_icache_key_gen;

    localparam int          Lat  = 8;
    localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;
    localparam logic [127:0] KEY_RST   = 128'hDDDDDDDD_EEEEEEEE_AAAAAAAA_DDDDDDDD;
    localparam logic [63:0]  NONCE_RST = 64'hBBBBEEEE_EEEEFFFF;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         req_i;
    logic         stall_i;
    logic         valid_o;
    logic [127:0] key_o;
    logic [63:0]  nonce_o;
    logic         busy_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int dbl_valid = 0;
    logic last_valid = 1'b0;

    logic [63:0]  m_s;
    logic [127:0] first_key;
    logic [63:0]  first_nonce;

    always #5 clk = ~clk;

    ibex_icache_key_gen #(.Latency(Lat), .Seed(SEED)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
`ifdef IBEX_ICACHE_KEYGEN_STALL_EN
        .stall_i (stall_i),
`endif
        .valid_o (valid_o),
        .key_o   (key_o),
        .nonce_o (nonce_o),
        .busy_o  (busy_o)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o && last_valid) dbl_valid <= dbl_valid + 1;
        last_valid <= valid_o;
    end

    // Reference: produce Latency generator outputs; key is the 3rd/2nd-last, nonce the last.
    task automatic model_gen(output logic [127:0] k, output logic [63:0] n);
        logic [63:0] xs[$];
        for (int i = 0; i < Lat; i++) begin
            m_s = m_s ^ (m_s << 13);
            m_s = m_s ^ (m_s >> 7);
            m_s = m_s ^ (m_s << 17);
            xs.push_back(m_s);
        end
        k = {xs[Lat-3], xs[Lat-2]};
        n = xs[Lat-1];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        req_i = 1'b0;
        stall_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        m_s = SEED;
    endtask

    // Raise req in IDLE, run until valid; drop_after>0 drops req after that many BUSY cycles.
    task automatic do_request(input int drop_after, input int stall_n, input bit noise,
                              output int lat, output int busy_cnt, output int vcyc,
                              output logic [127:0] k, output logic [63:0] n);
        int stalls_left;
        stalls_left = stall_n;
        lat = -1;
        busy_cnt = 0;
        vcyc = 0;
        k = '0;
        n = '0;
        @(negedge clk);
        req_i = 1'b1;
        stall_i = noise ? 1'($urandom) : 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (valid_o) begin
                lat = i;
                vcyc = cyc;
                k = key_o;
                n = nonce_o;
                req_i = 1'b0;
                stall_i = noise ? 1'($urandom) : 1'b0;
                break;
            end
            if (busy_o) begin
                busy_cnt++;
                if (drop_after > 0 && busy_cnt == drop_after) req_i = 1'b0;
                if (stalls_left > 0 && (i % 2 == 0)) begin
                    stall_i = 1'b1;
                    stalls_left--;
                end else begin
                    stall_i = 1'b0;
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (key_o !== KEY_RST || nonce_o !== NONCE_RST || valid_o !== 1'b0 || busy_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle cyc%0d: key=%h nonce=%h valid=%b busy=%b, required key=%h nonce=%h valid=0 busy=0",
                         i, key_o, nonce_o, valid_o, busy_o, KEY_RST, NONCE_RST);
            end
        end
    endtask

    task automatic test_single();
        int lat, bc, vc;
        logic [127:0] k, ek;
        logic [63:0] n, en;
        do_reset();
        do_request(0, 0, 1'b0, lat, bc, vc, k, n);
        model_gen(ek, en);
        first_key = ek;
        first_nonce = en;
        checks++;
        if (lat !== Lat + 1) begin
            failures++;
            $display("FAIL single_latency: got %0d, required %0d", lat, Lat + 1);
        end
        checks++;
        if (bc !== Lat) begin
            failures++;
            $display("FAIL single_busy_cycles: got %0d, required %0d", bc, Lat);
        end
        checks++;
        if (k !== ek || n !== en) begin
            failures++;
            $display("FAIL single_key: got %h/%h, required %h/%h", k, n, ek, en);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, vc1, vc2;
        logic [127:0] k, ek;
        logic [63:0] n, en;
        do_request(0, 0, 1'b0, lat, bc, vc1, k, n);
        model_gen(ek, en);
        do_request(0, 0, 1'b0, lat, bc, vc2, k, n);
        model_gen(ek, en);
        checks++;
        if (vc2 - vc1 !== Lat + 2) begin
            failures++;
            $display("FAIL b2b_period: got %0d, required %0d", vc2 - vc1, Lat + 2);
        end
        checks++;
        if (k !== ek || n !== en) begin
            failures++;
            $display("FAIL b2b_key: got %h/%h, required %h/%h", k, n, ek, en);
        end
        @(negedge clk);
        checks++;
        if (dbl_valid !== 0 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_single_pulse: consecutive=%0d valid=%b, required 0/0", dbl_valid, valid_o);
        end
    endtask

    task automatic test_drop();
        int lat, bc, vc;
        logic [127:0] k;
        logic [63:0] n;
        do_reset();
        do_request(3, 0, 1'b0, lat, bc, vc, k, n);
        checks++;
        if (lat !== Lat + 1 || k !== first_key || n !== first_nonce) begin
            failures++;
            $display("FAIL drop_req: lat=%0d key=%h nonce=%h, required lat=%0d key=%h nonce=%h",
                     lat, k, n, Lat + 1, first_key, first_nonce);
        end
    endtask

    task automatic test_reset_mid_busy();
        int lat, bc, vc, nb;
        bit saw_valid;
        logic [127:0] k, ek;
        logic [63:0] n, en;
        saw_valid = 1'b0;
        nb = 0;
        @(negedge clk);
        req_i = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 50 && nb < 5; i++) begin
            @(negedge clk);
            if (valid_o) saw_valid = 1'b1;
            if (busy_o) nb++;
        end
        rst_ni = 1'b0;
        req_i = 1'b0;
        #1;
        checks++;
        if (saw_valid || nb !== 5 || key_o !== KEY_RST || nonce_o !== NONCE_RST || valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_busy_reset: pulse=%b busy_seen=%0d key=%h nonce=%h valid=%b busy=%b, required no pulse, 5 busy, reset values",
                     saw_valid, nb, key_o, nonce_o, valid_o, busy_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        m_s = SEED;
        do_request(0, 0, 1'b0, lat, bc, vc, k, n);
        model_gen(ek, en);
        checks++;
        if (k !== ek || n !== en || k !== first_key) begin
            failures++;
            $display("FAIL mid_busy_restart: got %h/%h, required %h/%h", k, n, ek, en);
        end
    endtask

    task automatic test_random();
        int lat, bc, vc, drop, sn, elat;
        logic [127:0] k, ek;
        logic [63:0] n, en;
        for (int t = 0; t < 12; t++) begin
            drop = $urandom_range(0, Lat);
`ifdef IBEX_ICACHE_KEYGEN_STALL_EN
            sn = $urandom_range(0, 6);
`else
            sn = 0;
`endif
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_request(drop, sn, 1'b0, lat, bc, vc, k, n);
            model_gen(ek, en);
            elat = Lat + 1 + sn;
            checks++;
            if (lat !== elat || bc !== Lat + sn || k !== ek || n !== en) begin
                failures++;
                $display("FAIL random_gen%0d: lat=%0d busy=%0d key=%h nonce=%h, required lat=%0d busy=%0d key=%h nonce=%h",
                         t, lat, bc, k, n, elat, Lat + sn, ek, en);
            end
        end
    endtask

`ifdef IBEX_ICACHE_KEYGEN_STALL_EN
    task automatic test_stall();
        int lat, bc, vc;
        logic [127:0] k;
        logic [63:0] n;
        do_reset();
        do_request(0, 4, 1'b1, lat, bc, vc, k, n);
        checks++;
        if (lat !== Lat + 5 || k !== first_key || n !== first_nonce) begin
            failures++;
            $display("FAIL stall: lat=%0d key=%h nonce=%h, required lat=%0d key=%h nonce=%h",
                     lat, k, n, Lat + 5, first_key, first_nonce);
        end
    endtask
`endif

    initial begin
        rst_ni = 1'b0;
        req_i = 1'b0;
        stall_i = 1'b0;
        m_s = SEED;
        test_reset();
        test_single();
        test_back_to_back();
        test_drop();
        test_reset_mid_busy();
`ifdef IBEX_ICACHE_KEYGEN_STALL_EN
        test_stall();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
